// File: rtl/puf_soc_pkg.sv
// Shared types and helpers for the PUF SoC serial front end.
package puf_soc_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY, HOLD} rx_state_t;

    function automatic int chal_width(input int mux_len);
        return 2 * $clog2(mux_len);
    endfunction

endpackage

// File: rtl/puf_soc_uart_rx_if.sv
// Receiver-to-controller challenge handshake. o_parity_err exists only with PUF_UART_PARITY_EN.
interface puf_soc_uart_rx_if #(
    parameter int CHAL_W = 8
);
    logic              i_rx_clr;
    logic              o_rx_ready;
    logic              o_rx_valid;
    logic              o_rx_done;
    logic [CHAL_W-1:0] o_rx_data;
    logic              o_frame_err;
    logic              o_overrun;
`ifdef PUF_UART_PARITY_EN
    logic              o_parity_err;

    modport master (input i_rx_clr, output o_rx_ready, o_rx_valid, o_rx_done, o_rx_data,
                    o_frame_err, o_overrun, o_parity_err);
    modport slave  (output i_rx_clr, input o_rx_ready, o_rx_valid, o_rx_done, o_rx_data,
                    o_frame_err, o_overrun, o_parity_err);
`else
    modport master (input i_rx_clr, output o_rx_ready, o_rx_valid, o_rx_done, o_rx_data,
                    o_frame_err, o_overrun);
    modport slave  (output i_rx_clr, input o_rx_ready, o_rx_valid, o_rx_done, o_rx_data,
                    o_frame_err, o_overrun);
`endif
endinterface

// File: rtl/puf_uart_baud_cnt.sv
// Loadable baud down-counter; tick fires so the owner acts exactly load_val cycles after a load.
module puf_uart_baud_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick
);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      cnt_q <= '0;
        else if (load)                cnt_q <= load_val;
        else if (en && cnt_q != '0)   cnt_q <= cnt_q - CNT_W'(1);
    end

    assign tick = en && (cnt_q == CNT_W'(1));
endmodule

// File: rtl/puf_soc_uart_rx.sv
// 8N1 UART receiver that packs bytes little-endian into one PUF challenge word.
// Build option: PUF_UART_PARITY_EN adds an even-parity bit and o_parity_err.
module puf_soc_uart_rx
    import puf_soc_pkg::*;
#(
    parameter int MUX_LENGTH  = 16,
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_uart_rx,
    puf_soc_uart_rx_if.master bus
);
    localparam int CHAL_W       = chal_width(MUX_LENGTH);
    localparam int NUM_BYTES    = (CHAL_W + UART_DATA_BITS - 1) / UART_DATA_BITS;
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int BC_W         = $clog2(NUM_BYTES + 1);
`ifdef PUF_UART_PARITY_EN
    localparam int FRAME_BITS   = UART_DATA_BITS + 2;
`else
    localparam int FRAME_BITS   = UART_DATA_BITS + 1;
`endif
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT);

    rx_state_t                 state_q, state_d;
    logic [1:0]                sync_q;
    logic                      rx_s, rx_prev_q, fall;
    logic [2:0]                bit_idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [BC_W-1:0]           byte_cnt_q;
    logic [CHAL_W-1:0]         asm_q, asm_nxt, data_q;
    logic [3:0]                skip_q;
    logic                      done_q, valid_q, frame_err_q, overrun_q;
    logic                      tick, cnt_en, cnt_load;
    logic [CNT_W-1:0]          cnt_val;
    logic                      start_ok, shift_en, byte_ok, frame_bad, ovr, clr, skip_arm;
    logic                      last_byte, discard;
`ifdef PUF_UART_PARITY_EN
    logic                      par_bad, parity_err_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], i_uart_rx};
            rx_prev_q <= sync_q[1];
        end
    end

    // While skip_q runs, the remainder of an ignored frame must not look like new start bits.
    assign rx_s      = sync_q[1];
    assign fall      = rx_prev_q & ~rx_s & (skip_q == '0);
    assign last_byte = (byte_cnt_q == BC_W'(NUM_BYTES - 1));
    assign cnt_en    = (state_q inside {START, DATA, PARITY, STOP}) || (skip_q != '0);

    puf_uart_baud_cnt #(.CNT_W(CNT_W)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .en       (cnt_en),
        .load     (cnt_load),
        .load_val (cnt_val),
        .tick     (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cnt_load  = 1'b0;
        cnt_val   = FULL_BIT;
        start_ok  = 1'b0;
        shift_en  = 1'b0;
        byte_ok   = 1'b0;
        frame_bad = 1'b0;
        ovr       = 1'b0;
        clr       = 1'b0;
        skip_arm  = 1'b0;
`ifdef PUF_UART_PARITY_EN
        par_bad   = 1'b0;
`endif
        if (tick && skip_q != '0) cnt_load = 1'b1;
        case (state_q)
            IDLE: if (fall) begin
                cnt_load = 1'b1;
                if (done_q) begin
                    ovr      = 1'b1;
                    skip_arm = 1'b1;
                end else begin
                    state_d = START;
                    cnt_val = HALF_BIT;
                end
            end
            START: if (tick) begin
                if (!rx_s) begin
                    state_d  = DATA;
                    start_ok = 1'b1;
                    cnt_load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: if (tick) begin
                shift_en = 1'b1;
                cnt_load = 1'b1;
                if (bit_idx_q == 3'(UART_DATA_BITS - 1))
`ifdef PUF_UART_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
            end
`ifdef PUF_UART_PARITY_EN
            PARITY: if (tick) begin
                if (rx_s != ^shift_q) begin
                    par_bad = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d  = STOP;
                    cnt_load = 1'b1;
                end
            end
`endif
            STOP: if (tick) begin
                if (rx_s) begin
                    byte_ok = 1'b1;
                    state_d = last_byte ? HOLD : IDLE;
                end else begin
                    frame_bad = 1'b1;
                    state_d   = IDLE;
                end
            end
            HOLD: begin
                if (bus.i_rx_clr) begin
                    clr     = 1'b1;
                    state_d = IDLE;
                end
                // A clear in the same cycle suppresses the overrun but the frame is still skipped.
                if (fall) begin
                    skip_arm = 1'b1;
                    cnt_load = 1'b1;
                    ovr      = !bus.i_rx_clr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        asm_nxt = asm_q;
        for (int i = 0; i < CHAL_W; i++)
            if (i / UART_DATA_BITS == int'(byte_cnt_q)) asm_nxt[i] = shift_q[i % UART_DATA_BITS];
    end

`ifdef PUF_UART_PARITY_EN
    assign discard = frame_bad | par_bad;
`else
    assign discard = frame_bad;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_cnt_q  <= '0;
            asm_q       <= '0;
            data_q      <= '0;
            skip_q      <= '0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_bad;
            overrun_q   <= ovr;
            if (skip_arm)                    skip_q <= 4'(FRAME_BITS);
            else if (tick && skip_q != '0)   skip_q <= skip_q - 4'd1;
            if (start_ok) begin
                bit_idx_q <= '0;
                if (byte_cnt_q == '0) valid_q <= 1'b1;
            end
            if (shift_en) begin
                shift_q   <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
                bit_idx_q <= bit_idx_q + 3'd1;
            end
            // Bytes assemble privately so o_rx_data only ever changes to a complete word.
            if (byte_ok) begin
                asm_q <= asm_nxt;
                if (last_byte) begin
                    data_q     <= asm_nxt;
                    done_q     <= 1'b1;
                    valid_q    <= 1'b0;
                    byte_cnt_q <= '0;
                end else begin
                    byte_cnt_q <= byte_cnt_q + BC_W'(1);
                end
            end
            if (discard) begin
                byte_cnt_q <= '0;
                valid_q    <= 1'b0;
            end
            if (clr) done_q <= 1'b0;
        end
    end

`ifdef PUF_UART_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_err_q <= 1'b0;
        else     parity_err_q <= par_bad;
    end
    assign bus.o_parity_err = parity_err_q;
`endif

    assign bus.o_rx_ready  = (state_q == IDLE) && (byte_cnt_q == '0) && !done_q;
    assign bus.o_rx_valid  = valid_q;
    assign bus.o_rx_done   = done_q;
    assign bus.o_rx_data   = data_q;
    assign bus.o_frame_err = frame_err_q;
    assign bus.o_overrun   = overrun_q;
endmodule

// File: doc/puf_soc_uart_rx.md
Name: puf_soc_uart_rx

Overview:
UART receiver and challenge assembler that sits directly upstream of puf_soc_cntrlr.
- Deserialises 8N1 frames from the host serial line.
- Packs consecutive bytes into one challenge word of 2*$clog2(MUX_LENGTH) bits.
- Presents the word to the controller with ready/valid/done status and holds it until the controller clears it.

Parameters:
MUX_LENGTH, 16, ring-oscillator mux depth; sets challenge width CHAL_W = 2*$clog2(MUX_LENGTH).
CLK_FREQ_HZ, 100_000_000, system clock frequency.
BAUD, 115200, serial bit rate; localparam CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (must be >= 4).
Derived localparam NUM_BYTES = ceil(CHAL_W/8).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
i_uart_rx  in  1  asynchronous serial line, idle high
i_rx_clr  in  1  controller acknowledge; clears a pending challenge
o_rx_ready  out  1  receiver idle with no pending challenge
o_rx_valid  out  1  challenge frame(s) in progress
o_rx_done  out  1  complete challenge available (level)
o_rx_data  out  CHAL_W  assembled challenge, stable while o_rx_done=1
o_frame_err  out  1  one-cycle pulse when a stop bit is sampled low
o_overrun  out  1  one-cycle pulse when a start bit arrives while o_rx_done=1

Behaviour:
- Reset: all outputs 0 except o_rx_ready=1; FSM to IDLE; byte count 0; synchroniser flops set to 1.
- i_uart_rx passes through a 2-flop synchroniser; all sampling uses the synchronised value (2-cycle latency).
- FSM states: IDLE, START, DATA, STOP, HOLD.
- IDLE:
  - Falling edge of the line with o_rx_done=0 -> START; the baud counter loads CLKS_PER_BIT/2.
  - Falling edge with o_rx_done=1 -> pulse o_overrun and stay IDLE; the frame is ignored.
- START: at counter expiry, resample the line.
  - Line low -> DATA, bit index 0, counter reloads CLKS_PER_BIT.
  - Line high -> false start; return to IDLE with no error flag.
- DATA: sample one bit every CLKS_PER_BIT, LSB first, into a shift register. After bit 7 -> STOP.
- STOP: sample the stop bit.
  - High: byte k is written into o_rx_data[8k +: 8], clipped to CHAL_W. Bytes arrive little-endian; excess bits of the last byte are dropped. Byte count increments.
  - Count < NUM_BYTES -> IDLE, waiting for the next byte.
  - Count == NUM_BYTES -> HOLD. o_rx_done is set on the cycle after the stop sample; count resets to 0.
  - Low: pulse o_frame_err; discard all partially assembled bytes; count to 0; o_rx_data unchanged; -> IDLE.
- HOLD: o_rx_done=1 and o_rx_data is frozen.
  - i_rx_clr=1 -> clear o_rx_done on the next edge, -> IDLE.
  - A start bit seen while in HOLD is handled as an overrun, as in IDLE.
- o_rx_ready = (state==IDLE) && byte count==0 && !o_rx_done.
- o_rx_valid = 1 from start-bit validation of byte 0 until the stop sample of the last byte, or until a frame error.
- i_rx_clr outside HOLD: no effect.
- i_rx_clr and a start edge in the same cycle while in HOLD: the clear wins; no overrun; the new frame is not captured.
- Reset mid-frame: immediate return to the reset state; partial data is lost.

Optional Feature:
PUF_UART_PARITY_EN:
- Defined:
  - Adds a PARITY state between DATA and STOP, sampling an even-parity bit.
  - Parity mismatch behaves like a frame error (discard, count 0), but pulses an extra output, o_parity_err, 1 bit, reset 0.
- Undefined: no PARITY state and no o_parity_err port; pure 8N1.

Decomposition:
- Shared package puf_soc_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP, PARITY, HOLD}.
  - Function chal_width(mux_len) returning 2*$clog2(mux_len).
  - Constant UART_DATA_BITS=8.
- Sub-module puf_uart_baud_cnt:
  - Loadable down-counter with a tick output at zero.
  - Load values are CLKS_PER_BIT/2 and CLKS_PER_BIT.
  - Reused by a future UART TX.

Test Plan:
All scenarios use CLK_FREQ_HZ=1_000_000, BAUD=100_000 (10 clocks/bit) and MUX_LENGTH=16 (CHAL_W=8, NUM_BYTES=1), unless stated otherwise.
1. Reset held 5 cycles, line idle -> o_rx_ready=1, o_rx_done=0, o_rx_data=8'h00.
2. Send byte 8'hA5 -> o_rx_valid rises about 7 cycles after the start edge (2 sync + 5 half-bit). o_rx_done=1 with o_rx_data=8'hA5 one cycle after the stop sample. Held until i_rx_clr; o_rx_ready returns 1 the cycle after the clear.
3. Line pulse low for 3 cycles -> no o_rx_valid, no error, state back to IDLE.
4. Send 8'h3C with the stop bit low -> o_frame_err one-cycle pulse, o_rx_done stays 0, o_rx_data unchanged.
5. With o_rx_done=1 holding 8'h11, send 8'h22 -> o_overrun pulse, o_rx_data stays 8'h11.
6. MUX_LENGTH=1024 (CHAL_W=20, NUM_BYTES=3), send 8'h34, 8'h12, 8'hF5 -> o_rx_data=20'h51234 after the third stop bit. Assert rst mid-second-byte and confirm all outputs return to reset values.
